// File: rtl/win_checker_if.sv
// Command/result bundle between the connect-four control FSM (master) and
// the win checker (slave).
interface win_checker_if;
    logic       logic_go;
    logic [2:0] mem_address;
    logic [5:0] write_to_onoff;
    logic [5:0] write_to_player;
    logic       cur_player;
    logic       busy;
    logic       done;
    logic       logic_result;
    logic       winner;
    logic       draw;
    logic [2:0] win_col;
    logic [2:0] win_row;
    logic [1:0] win_dir;

    modport master (
        output logic_go, mem_address, write_to_onoff, write_to_player, cur_player,
        input  busy, done, logic_result, winner, draw, win_col, win_row, win_dir
    );

    modport slave (
        input  logic_go, mem_address, write_to_onoff, write_to_player, cur_player,
        output busy, done, logic_result, winner, draw, win_col, win_row, win_dir
    );
endinterface

// File: rtl/win_checker.sv
// Shadow 7x6 connect-four board; after every column write, scans each cell as
// the anchor of a four-in-a-row for the mover and reports win/draw.
module win_checker (
    input  logic          clk,
    input  logic          reset,
    input  logic          logic_reset,
    win_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam int STEP [4] = '{6, 1, 7, 5};

    state_t      state_reg;
    logic [41:0] onoff_reg;
    logic [41:0] owner_reg;
    logic        pl_reg;
    logic [2:0]  col_reg;
    logic [2:0]  row_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        result_reg;
    logic        winner_reg;
    logic        draw_reg;
    logic [2:0]  win_col_reg;
    logic [2:0]  win_row_reg;
    logic [1:0]  win_dir_reg;

    logic [63:0] match_vec;
    logic [5:0]  anchor;
    logic [5:0]  wbase;
    logic [3:0]  in_bounds;
    logic [3:0]  line_hit;
    logic [1:0]  hit_dir;
    logic        any_hit;
    logic        last_anchor;
    logic        col_le3;
    logic        row_le2;

    // Padded so anchor + 3*step never leaves the vector; bounds mask the rest.
    assign match_vec   = {22'd0, onoff_reg & ~(owner_reg ^ {42{pl_reg}})};
    assign anchor      = ({3'd0, col_reg} * 6'd6) + {3'd0, row_reg};
    assign wbase       = {3'd0, bus.mem_address} * 6'd6;
    assign col_le3     = (col_reg <= 3'd3);
    assign row_le2     = (row_reg <= 3'd2);
    assign in_bounds   = {col_le3 & ~row_le2, col_le3 & row_le2, row_le2, col_le3};
    assign last_anchor = (col_reg == 3'd6) && (row_reg == 3'd5);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dir
            logic [3:0] cells;
            for (genvar gj = 0; gj < 4; gj++) begin : g_cell
                assign cells[gj] = match_vec[anchor + 6'(STEP[gi] * gj)];
            end
            assign line_hit[gi] = (&cells) & in_bounds[gi];
        end
    endgenerate

    assign any_hit = |line_hit;

    always_comb begin
        hit_dir = 2'd0;
        if (line_hit[0])      hit_dir = 2'd0;
        else if (line_hit[1]) hit_dir = 2'd1;
        else if (line_hit[2]) hit_dir = 2'd2;
        else if (line_hit[3]) hit_dir = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (reset || logic_reset) begin
            state_reg   <= IDLE;
            onoff_reg   <= '0;
            owner_reg   <= '0;
            pl_reg      <= 1'b0;
            col_reg     <= '0;
            row_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= 1'b0;
            winner_reg  <= 1'b0;
            draw_reg    <= 1'b0;
            win_col_reg <= '0;
            win_row_reg <= '0;
            win_dir_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.logic_go) begin
                        if (bus.mem_address != 3'd7) begin
                            onoff_reg[wbase +: 6] <= bus.write_to_onoff;
                            owner_reg[wbase +: 6] <= bus.write_to_player;
                        end
                        pl_reg      <= bus.cur_player;
                        result_reg  <= 1'b0;
                        winner_reg  <= 1'b0;
                        draw_reg    <= 1'b0;
                        win_col_reg <= '0;
                        win_row_reg <= '0;
                        win_dir_reg <= '0;
                        col_reg     <= '0;
                        row_reg     <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SCAN;
                    end
                end
                SCAN: begin
                    if (any_hit) begin
                        win_col_reg <= col_reg;
                        win_row_reg <= row_reg;
                        win_dir_reg <= hit_dir;
                        result_reg  <= 1'b1;
                        winner_reg  <= pl_reg;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= REPORT;
                    end else if (last_anchor) begin
                        result_reg  <= &onoff_reg;
                        draw_reg    <= &onoff_reg;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= REPORT;
                    end else if (row_reg == 3'd5) begin
                        row_reg <= '0;
                        col_reg <= col_reg + 3'd1;
                    end else begin
                        row_reg <= row_reg + 3'd1;
                    end
                end
                REPORT: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.logic_result = result_reg;
    assign bus.winner       = winner_reg;
    assign bus.draw         = draw_reg;
    assign bus.win_col      = win_col_reg;
    assign bus.win_row      = win_row_reg;
    assign bus.win_dir      = win_dir_reg;
endmodule

// File: tb/tb_win_checker.sv
// Scoreboarded bench for win_checker: a board-level reference model predicts
// each check's outcome and latency; a monitor compares on every done pulse.
module tb_win_checker;
    logic clk = 1'b0;
    logic reset;
    logic logic_reset;

    win_checker_if bus();

    win_checker dut (
        .clk         (clk),
        .reset       (reset),
        .logic_reset (logic_reset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       res;
        bit       win;
        bit       drw;
        bit [2:0] c;
        bit [2:0] r;
        bit [1:0] d;
        int       lat;
        int       go_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   txn = 0;
    bit   bon  [7][6];
    bit   bown [7][6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired got 0 expected 1", name);
    endtask

    task automatic clear_model();
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) begin
                bon[c][r]  = 1'b0;
                bown[c][r] = 1'b0;
            end
    endtask

    // Reference: first anchor in idx = 6c+r order, lowest direction, all four cells on board.
    function automatic exp_t model_check(input bit pl);
        exp_t e;
        int   dc [4] = '{1, 0, 1, 1};
        int   dr [4] = '{0, 1, 1, -1};
        bit   found = 0;
        bit   full = 1;
        e = '{default: 0};
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                for (int d = 0; d < 4; d++) begin
                    int ec = c + 3 * dc[d];
                    int er = r + 3 * dr[d];
                    if (!found && ec >= 0 && ec <= 6 && er >= 0 && er <= 5) begin
                        bit all = 1;
                        for (int i = 0; i < 4; i++)
                            if (!(bon[c + i*dc[d]][r + i*dr[d]] && bown[c + i*dc[d]][r + i*dr[d]] == pl))
                                all = 0;
                        if (all) begin
                            found = 1;
                            e.res = 1; e.win = pl;
                            e.c = 3'(c); e.r = 3'(r); e.d = 2'(d);
                            e.lat = 6*c + r + 1;
                        end
                    end
                end
        if (!found) begin
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 6; r++)
                    if (!bon[c][r]) full = 0;
            e.res = full;
            e.drw = full;
            e.lat = 42;
        end
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) bound_expired("wait_idle");
    endtask

    task automatic issue_go(input bit [2:0] addr, input bit [5:0] on, input bit [5:0] own, input bit pl);
        exp_t e;
        wait_idle();
        bus.mem_address     = addr;
        bus.write_to_onoff  = on;
        bus.write_to_player = own;
        bus.cur_player      = pl;
        bus.logic_go        = 1'b1;
        if (addr <= 3'd6)
            for (int r = 0; r < 6; r++) begin
                bon[addr][r]  = on[r];
                bown[addr][r] = own[r];
            end
        e = model_check(pl);
        e.go_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.logic_go = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            bound_expired("done_timeout");
            exp_q.delete();
        end
    endtask

    task automatic go_check(input bit [2:0] addr, input bit [5:0] on, input bit [5:0] own, input bit pl);
        issue_go(addr, on, own, pl);
        wait_done();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},   int'(bus.busy), 0);
        check({tag, "_done"},   int'(bus.done), 0);
        check({tag, "_result"}, int'(bus.logic_result), 0);
        check({tag, "_draw"},   int'(bus.draw), 0);
        check({tag, "_winloc"}, int'({bus.winner, bus.win_col, bus.win_row, bus.win_dir}), 0);
    endtask

    task automatic new_game();
        @(negedge clk);
        logic_reset = 1'b1;
        @(negedge clk);
        logic_reset = 1'b0;
        clear_model();
        check_cleared("logic_reset");
    endtask

    // Monitor: one comparison set per done pulse.
    always @(negedge clk) begin
        if (!reset && !logic_reset && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                last_exp = e;
                txn++;
                $display("txn %0d: result=%0d winner=%0d draw=%0d col=%0d row=%0d dir=%0d latency=%0d",
                         txn, bus.logic_result, bus.winner, bus.draw, bus.win_col,
                         bus.win_row, bus.win_dir, cyc - e.go_cyc);
                check("latency", cyc - e.go_cyc, e.lat);
                check("busy_at_done", int'(bus.busy), 0);
                check("logic_result", int'(bus.logic_result), int'(e.res));
                check("draw", int'(bus.draw), int'(e.drw));
                if (e.res && !e.drw) begin
                    check("winner", int'(bus.winner), int'(e.win));
                    check("win_col", int'(bus.win_col), int'(e.c));
                    check("win_row", int'(bus.win_row), int'(e.r));
                    check("win_dir", int'(bus.win_dir), int'(e.d));
                end
            end
        end
    end

    initial begin
        bus.logic_go = 1'b0;
        bus.mem_address = '0;
        bus.write_to_onoff = '0;
        bus.write_to_player = '0;
        bus.cur_player = 1'b0;
        logic_reset = 1'b0;
        reset = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_cleared("reset");

        // Vertical win in column 2.
        go_check(3'd2, 6'b001111, 6'b001111, 1'b1);
        new_game();

        // Horizontal win along row 0 for player 0.
        for (int c = 0; c < 4; c++) go_check(3'(c), 6'b000001, 6'b000000, 1'b0);
        new_game();

        // Diagonal-down: player 1 on (0,3),(1,2),(2,1),(3,0) over player-0 fillers.
        go_check(3'd0, 6'b001111, 6'b001000, 1'b1);
        go_check(3'd1, 6'b000111, 6'b000100, 1'b1);
        go_check(3'd2, 6'b000011, 6'b000010, 1'b1);
        go_check(3'd7, 6'b000000, 6'b000000, 1'b0);
        go_check(3'd3, 6'b000001, 6'b000001, 1'b1);
        new_game();

        // Full board with no four-in-a-row.
        for (int c = 0; c < 7; c++)
            go_check(3'(c), 6'b111111, (c % 2 == 1) ? 6'b001100 : 6'b110011, 1'(c % 2));
        repeat (3) @(negedge clk);
        check("held_result", int'(bus.logic_result), int'(last_exp.res));
        check("held_draw", int'(bus.draw), int'(last_exp.drw));

        // Abort a full-length scan with logic_reset.
        issue_go(3'd7, 6'b0, 6'b0, 1'b0);
        repeat (10) @(negedge clk);
        logic_reset = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        logic_reset = 1'b0;
        clear_model();
        check_cleared("abort");
        repeat (50) @(negedge clk);
        go_check(3'd7, 6'b111111, 6'b111111, 1'b1);

        // A write strobe while busy must be dropped.
        issue_go(3'd6, 6'b001111, 6'b001111, 1'b1);
        repeat (3) @(negedge clk);
        bus.mem_address = 3'd0;
        bus.write_to_onoff = 6'b001111;
        bus.write_to_player = 6'b001111;
        bus.cur_player = 1'b1;
        bus.logic_go = 1'b1;
        @(negedge clk);
        bus.logic_go = 1'b0;
        wait_done();
        go_check(3'd7, 6'b0, 6'b0, 1'b1);

        // Randomised column writes, with occasional busy strobes and new games.
        for (int t = 0; t < 60; t++) begin
            if (t % 12 == 11) new_game();
            issue_go(3'($urandom_range(0, 7)), 6'($urandom), 6'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0 && exp_q.size() != 0 && exp_q[$].lat > 6) begin
                repeat (2) @(negedge clk);
                bus.mem_address = 3'($urandom_range(0, 6));
                bus.write_to_onoff = 6'($urandom);
                bus.write_to_player = 6'($urandom);
                bus.logic_go = 1'b1;
                @(negedge clk);
                bus.logic_go = 1'b0;
            end
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
